// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 24
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic       acc_c;
    logic       dep_c;
    logic       main_from_in_c;
    logic       main_from_skid_c;
    logic       skid_from_in_c;
    logic [1:0] occ_nxt_c;

    assign acc_c = in_valid & in_ready;
    assign dep_c = out_valid & out_ready;

    // Next-state and load selects; flush overrides every transition.
    always_comb begin
        state_nxt        = state;
        main_from_in_c   = 1'b0;
        main_from_skid_c = 1'b0;
        skid_from_in_c   = 1'b0;
        occ_nxt_c        = 2'd0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_c) begin
                        state_nxt      = ONE;
                        main_from_in_c = 1'b1;
                    end
                end
                ONE: begin
                    if (acc_c && dep_c) begin
                        main_from_in_c = 1'b1;
                    end else if (acc_c) begin
                        state_nxt      = TWO;
                        skid_from_in_c = 1'b1;
                    end else if (dep_c) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (dep_c) begin
                        state_nxt        = ONE;
                        main_from_skid_c = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
        case (state_nxt)
            ONE:     occ_nxt_c = 2'd1;
            TWO:     occ_nxt_c = 2'd2;
            default: occ_nxt_c = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
            occupancy <= occ_nxt_c;
            // Control is zeroed whenever the stage goes empty; data is left as-is.
            if (state_nxt == EMPTY) begin
                out_ctrl <= '0;
            end else if (main_from_in_c) begin
                out_ctrl <= in_ctrl;
            end else if (main_from_skid_c) begin
                out_ctrl <= skid_ctrl;
            end
            if (main_from_in_c) begin
                out_data <= in_data;
            end else if (main_from_skid_c) begin
                out_data <= skid_data;
            end
            if (skid_from_in_c) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall and flush counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && ((occupancy != 2'd0) || in_valid) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers the counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [23:0]  in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [23:0]  out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]   stall_cnt;
    logic [3:0]   flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_reg #(.DATA_W(128), .CTRL_W(24), .CNT_W(4)) dut (
`else
    pipe_stage_reg #(.DATA_W(128), .CTRL_W(24)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] c, input logic [127:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_occ", 128'(occupancy), 128'(0));
        rst_neg_release();

        // First entry, one-cycle latency from EMPTY.
        out_ready = 1'b1;
        send(24'h0000A5, 128'h1234);
        check("first_valid", 128'(out_valid), 128'(1));
        check("first_ctrl", 128'(out_ctrl), 128'h0A5);
        check("first_data", out_data, 128'h1234);
        check("first_occ", 128'(occupancy), 128'(1));

        for (int i = 1; i <= 8; i++) begin
            send(24'(i), 128'(i));
            check("b2b_data", out_data, 128'(i));
            check("b2b_ctrl", 128'(out_ctrl), 128'(i));
            check("b2b_ready", 128'(in_ready), 128'(1));
            check("b2b_occ", 128'(occupancy), 128'(1));
        end

        // Drain: bubble zeroes control but keeps data.
        in_valid = 1'b0;
        tick();
        check("bubble_valid", 128'(out_valid), 128'(0));
        check("bubble_ctrl", 128'(out_ctrl), 128'(0));
        check("bubble_data", out_data, 128'(8));
        check("bubble_occ", 128'(occupancy), 128'(0));

        // Backpressure fills the skid buffer.
        out_ready = 1'b0;
        send(24'h000011, 128'hA);
        check("bp_a_occ", 128'(occupancy), 128'(1));
        check("bp_a_ready", 128'(in_ready), 128'(1));
        send(24'h000022, 128'hB);
        check("bp_b_occ", 128'(occupancy), 128'(2));
        check("bp_b_ready", 128'(in_ready), 128'(0));
        check("bp_b_main", out_data, 128'hA);
        check("bp_b_ctrl", 128'(out_ctrl), 128'h11);
        in_valid = 1'b0;
        tick();
        check("bp_hold_occ", 128'(occupancy), 128'(2));
        check("bp_hold_main", out_data, 128'hA);
        out_ready = 1'b1;
        tick();
        check("bp_rel_data", out_data, 128'hB);
        check("bp_rel_ctrl", 128'(out_ctrl), 128'h22);
        check("bp_rel_ready", 128'(in_ready), 128'(1));
        check("bp_rel_occ", 128'(occupancy), 128'(1));
        tick();
        check("bp_empty_valid", 128'(out_valid), 128'(0));
        check("bp_empty_occ", 128'(occupancy), 128'(0));

        // Flush at occupancy 2 with an input offered.
        out_ready = 1'b0;
        send(24'h00001A, 128'h1A);
        send(24'h00001B, 128'h1B);
        check("fl_pre_occ", 128'(occupancy), 128'(2));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 24'h0000CC;
        in_data  = 128'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_ctrl", 128'(out_ctrl), 128'(0));
        check("fl_occ", 128'(occupancy), 128'(0));
        check("fl_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_c_valid", 128'(out_valid), 128'(0));
        end

        // Flush at occupancy 1 with an acceptable input: input discarded too.
        send(24'h000033, 128'h33);
        check("fl1_pre_occ", 128'(occupancy), 128'(1));
        flush   = 1'b1;
        in_ctrl = 24'h000044;
        in_data = 128'h44;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", 128'(out_valid), 128'(0));
        check("fl1_occ", 128'(occupancy), 128'(0));
        tick();
        check("fl1_no_in_valid", 128'(out_valid), 128'(0));

        // Async reset mid-cycle at occupancy 2.
        out_ready = 1'b0;
        send(24'h000055, 128'h55);
        send(24'h000066, 128'h66);
        in_valid = 1'b0;
        check("ar_pre_occ", 128'(occupancy), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 128'(out_valid), 128'(0));
        check("ar_ctrl", 128'(out_ctrl), 128'(0));
        check("ar_occ", 128'(occupancy), 128'(0));
        check("ar_ready", 128'(in_ready), 128'(1));
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_after_valid", 128'(out_valid), 128'(0));

`ifdef PIPE_STAGE_PERF_EN
        check("cnt_rst_stall", 128'(stall_cnt), 128'(0));
        check("cnt_rst_flush", 128'(flush_cnt), 128'(0));
        out_ready = 1'b0;
        send(24'h000077, 128'h77);
        in_valid = 1'b0;
        check("cnt_stall_start", 128'(stall_cnt), 128'(0));
        for (int i = 0; i < 10; i++) tick();
        check("cnt_stall_10", 128'(stall_cnt), 128'(10));
        for (int i = 0; i < 10; i++) tick();
        check("cnt_stall_sat", 128'(stall_cnt), 128'(15));
        tick();
        check("cnt_stall_hold", 128'(stall_cnt), 128'(15));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_flush_one", 128'(flush_cnt), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_flush_idle", 128'(flush_cnt), 128'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic rst_neg_release();
        rst_n = 1'b1;
        tick();
    endtask

endmodule
